mult_pipe_16x16: RTL and testbench

- Pipelined 16x16 multiplier. Directly upstream of the accumulator stage; produces its MULT_8x8 and MULT_16x16 operands.
- Builds the product from four 9x9 signed partial products, so one array serves 16x16 mode and dual 8x8 mode.
- Per-operand signedness control.
- Configurable register stages with a valid flag that tracks data through the pipe.

---
 rtl/mult_pipe_pkg.sv | 21 ++
 rtl/mult_pp_9x9.sv | 43 ++++
 rtl/mult_pipe_16x16.sv | 155 +++++++++++++++
 tb/tb_mult_pipe_16x16.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pipe_pkg.sv
// Shared widths, rounding constant and helpers for the 16x16 pipelined multiplier.
package mult_pipe_pkg;

  localparam int OP_W   = 16;
  localparam int HALF_W = 8;
  localparam int PP_W   = 18;
  localparam int PROD_W = 32;

  localparam logic [PROD_W-1:0] ROUND_CONST = 32'h0000_8000;

  // Total pipeline latency in CE-qualified clock cycles.
  function automatic int lat(int in_reg, int pipe_reg, int out_reg);
    return in_reg + pipe_reg + out_reg;
  endfunction

  // Sign-extend an 18-bit partial product onto the 32-bit combine adder.
  function automatic logic [PROD_W-1:0] sext_pp(logic [PP_W-1:0] pp);
    return {{(PROD_W-PP_W){pp[PP_W-1]}}, pp};
  endfunction

endpackage

// File: rtl/mult_pp_9x9.sv
// One signed 9x9 partial-product multiplier with an optional CE-gated output register.
module mult_pp_9x9
  import mult_pipe_pkg::*;
#(
  parameter int REG = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ce_i,
  input  logic signed [HALF_W:0] a_i,
  input  logic signed [HALF_W:0] b_i,
  output logic signed [PP_W-1:0] p_o
);

  logic signed [PP_W-1:0] a_x;
  logic signed [PP_W-1:0] b_x;
  logic signed [PP_W-1:0] p_d;

  // The 9x9 product always fits in 18 bits, so multiplying at 18 bits is exact.
  assign a_x = PP_W'(a_i);
  assign b_x = PP_W'(b_i);
  assign p_d = a_x * b_x;

  generate
    if (REG != 0) begin : g_reg
      logic signed [PP_W-1:0] p_q;

      // Partial-product register, advancing only with the shared clock enable.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          p_q <= '0;
        end else if (ce_i) begin
          p_q <= p_d;
        end
      end

      assign p_o = p_q;
    end else begin : g_comb
      assign p_o = p_d;
    end
  endgenerate

endmodule

// File: rtl/mult_pipe_16x16.sv
// Pipelined 16x16 multiplier built from four 9x9 signed partial products.
// Serves both 16x16 mode and dual 8x8 mode from the same array.
// Build option: define MULT_PIPE_ROUND_EN to add ROUND_CONST to the 32-bit
// product (round-half-up Q15 on MULT_16x16_HI); the 8x8 outputs are unaffected.
module mult_pipe_16x16
  import mult_pipe_pkg::*;
#(
  parameter int IN_REG   = 1,
  parameter int PIPE_REG = 1,
  parameter int OUT_REG  = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CE,
  input  logic            VALID_IN,
  input  logic [OP_W-1:0] A,
  input  logic [OP_W-1:0] B,
  input  logic            A_SIGNED,
  input  logic            B_SIGNED,
  output logic [OP_W-1:0] MULT_8x8_TOP,
  output logic [OP_W-1:0] MULT_8x8_BOT,
  output logic [OP_W-1:0] MULT_16x16_HI,
  output logic [OP_W-1:0] MULT_16x16_LO,
  output logic            VALID_OUT
);

  logic [OP_W-1:0] a_s0, b_s0;
  logic            as_s0, bs_s0, v0;

  generate
    if (IN_REG != 0) begin : g_in_reg
      logic [OP_W-1:0] a_q, b_q;
      logic            as_q, bs_q, v0_q;

      // Input capture: data loads on every enabled cycle, valid tracks VALID_IN.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          a_q  <= '0;
          b_q  <= '0;
          as_q <= 1'b0;
          bs_q <= 1'b0;
          v0_q <= 1'b0;
        end else if (CE) begin
          a_q  <= A;
          b_q  <= B;
          as_q <= A_SIGNED;
          bs_q <= B_SIGNED;
          v0_q <= VALID_IN;
        end
      end

      assign a_s0  = a_q;
      assign b_s0  = b_q;
      assign as_s0 = as_q;
      assign bs_s0 = bs_q;
      assign v0    = v0_q;
    end else begin : g_in_comb
      assign a_s0  = A;
      assign b_s0  = B;
      assign as_s0 = A_SIGNED;
      assign bs_s0 = B_SIGNED;
      assign v0    = VALID_IN;
    end
  endgenerate

  // High halves carry the operand sign when signed; low halves are always unsigned.
  logic signed [HALF_W:0] ah, al, bh, bl;
  assign ah = {as_s0 & a_s0[OP_W-1], a_s0[OP_W-1:HALF_W]};
  assign al = {1'b0, a_s0[HALF_W-1:0]};
  assign bh = {bs_s0 & b_s0[OP_W-1], b_s0[OP_W-1:HALF_W]};
  assign bl = {1'b0, b_s0[HALF_W-1:0]};

  logic signed [PP_W-1:0] pp_hh, pp_hl, pp_lh, pp_ll;

  mult_pp_9x9 #(.REG(PIPE_REG)) u_pp_hh (
    .clk_i(CLK), .rst_i(RST), .ce_i(CE), .a_i(ah), .b_i(bh), .p_o(pp_hh));
  mult_pp_9x9 #(.REG(PIPE_REG)) u_pp_hl (
    .clk_i(CLK), .rst_i(RST), .ce_i(CE), .a_i(ah), .b_i(bl), .p_o(pp_hl));
  mult_pp_9x9 #(.REG(PIPE_REG)) u_pp_lh (
    .clk_i(CLK), .rst_i(RST), .ce_i(CE), .a_i(al), .b_i(bh), .p_o(pp_lh));
  mult_pp_9x9 #(.REG(PIPE_REG)) u_pp_ll (
    .clk_i(CLK), .rst_i(RST), .ce_i(CE), .a_i(al), .b_i(bl), .p_o(pp_ll));

  logic v1;

  generate
    if (PIPE_REG != 0) begin : g_v1_reg
      logic v1_q;

      // Valid flag alongside the partial-product registers.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          v1_q <= 1'b0;
        end else if (CE) begin
          v1_q <= v0;
        end
      end

      assign v1 = v1_q;
    end else begin : g_v1_comb
      assign v1 = v0;
    end
  endgenerate

  logic [PROD_W-1:0] p_d;

  // Combine adder, modulo 2^32; the optional rounding constant rides on the same sum.
  always_comb begin
    p_d = (sext_pp(pp_hh) << 16)
        + ((sext_pp(pp_hl) + sext_pp(pp_lh)) << 8)
        + sext_pp(pp_ll);
`ifdef MULT_PIPE_ROUND_EN
    p_d = p_d + ROUND_CONST;
`endif
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [PROD_W-1:0] p_q;
      logic [OP_W-1:0]   top_q, bot_q;
      logic              v2_q;

      // Output register loads data only for valid samples, so outputs stay 0
      // after reset until the first real result and bubbles leave it untouched.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          p_q   <= '0;
          top_q <= '0;
          bot_q <= '0;
          v2_q  <= 1'b0;
        end else if (CE) begin
          v2_q <= v1;
          if (v1) begin
            p_q   <= p_d;
            top_q <= pp_hh[OP_W-1:0];
            bot_q <= pp_ll[OP_W-1:0];
          end
        end
      end

      assign MULT_16x16_HI = p_q[PROD_W-1:OP_W];
      assign MULT_16x16_LO = p_q[OP_W-1:0];
      assign MULT_8x8_TOP  = top_q;
      assign MULT_8x8_BOT  = bot_q;
      assign VALID_OUT     = v2_q;
    end else begin : g_out_comb
      assign MULT_16x16_HI = p_d[PROD_W-1:OP_W];
      assign MULT_16x16_LO = p_d[OP_W-1:0];
      assign MULT_8x8_TOP  = pp_hh[OP_W-1:0];
      assign MULT_8x8_BOT  = pp_ll[OP_W-1:0];
      assign VALID_OUT     = v1;
    end
  endgenerate

endmodule

// File: tb/tb_mult_pipe_16x16.sv
// Self-checking bench for mult_pipe_16x16 at default parameters (LAT = 3).
// Honours MULT_PIPE_ROUND_EN when the build defines it.
module tb_mult_pipe_16x16;
  import mult_pipe_pkg::*;

  localparam int LAT = lat(1, 1, 1);
`ifdef MULT_PIPE_ROUND_EN
  localparam logic [31:0] RND = 32'h0000_8000;
`else
  localparam logic [31:0] RND = 32'h0000_0000;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE = 1'b1;
  logic        VALID_IN = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        A_SIGNED = 1'b0, B_SIGNED = 1'b0;
  logic [15:0] MULT_8x8_TOP, MULT_8x8_BOT, MULT_16x16_HI, MULT_16x16_LO;
  logic        VALID_OUT;

  mult_pipe_16x16 dut (
    .CLK(CLK), .RST(RST), .CE(CE), .VALID_IN(VALID_IN),
    .A(A), .B(B), .A_SIGNED(A_SIGNED), .B_SIGNED(B_SIGNED),
    .MULT_8x8_TOP(MULT_8x8_TOP), .MULT_8x8_BOT(MULT_8x8_BOT),
    .MULT_16x16_HI(MULT_16x16_HI), .MULT_16x16_LO(MULT_16x16_LO),
    .VALID_OUT(VALID_OUT));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] hi, lo, top, bot;
  } exp_t;

  typedef struct {
    logic [15:0] a, b;
    logic        as, bs;
    logic [31:0] p;     // exact product, before optional rounding
    logic [15:0] top, bot;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: interpret operands as integers and multiply.
  function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic as, logic bs);
    exp_t e;
    longint av, bv, ahv, bhv, prod, top, bot;
    logic [31:0] p;
    av   = as ? longint'($signed(a)) : longint'(a);
    bv   = bs ? longint'($signed(b)) : longint'(b);
    ahv  = as ? longint'($signed(a[15:8])) : longint'(a[15:8]);
    bhv  = bs ? longint'($signed(b[15:8])) : longint'(b[15:8]);
    prod = av * bv;
    p    = prod[31:0] + RND;
    top  = ahv * bhv;
    bot  = longint'(a[7:0]) * longint'(b[7:0]);
    e.hi  = p[31:16];
    e.lo  = p[15:0];
    e.top = top[15:0];
    e.bot = bot[15:0];
    return e;
  endfunction

  // Scoreboard keyed by CE-cycle index of capture; output after CE-cycle n
  // shows the sample captured at CE-cycle n-LAT+1.
  exp_t exp_map[int];
  int   ce_idx = 0;
  bit   mon_en = 1'b0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_map.delete();
      ce_idx = 0;
    end else if (CE) begin
      ce_idx++;
      if (VALID_IN) exp_map[ce_idx] = model(A, B, A_SIGNED, B_SIGNED);
    end
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      if (RST) begin
        chk("mon_rst_valid", {31'b0, VALID_OUT}, 32'd0);
        chk("mon_rst_prod", {MULT_16x16_HI, MULT_16x16_LO}, 32'd0);
      end else if (exp_map.exists(ce_idx - LAT + 1)) begin
        exp_t e;
        e = exp_map[ce_idx - LAT + 1];
        chk("mon_valid", {31'b0, VALID_OUT}, 32'd1);
        chk("mon_prod", {MULT_16x16_HI, MULT_16x16_LO}, {e.hi, e.lo});
        chk("mon_8x8", {MULT_8x8_TOP, MULT_8x8_BOT}, {e.top, e.bot});
      end else begin
        chk("mon_bubble", {31'b0, VALID_OUT}, 32'd0);
      end
    end
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic as, input logic bs, input logic v);
    A = a; B = b; A_SIGNED = as; B_SIGNED = bs; VALID_IN = v;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE_0001, 16'hFE01, 16'hFE01};
    vecs[1] = '{16'h8000, 16'h8000, 1'b1, 1'b1, 32'h4000_0000, 16'h4000, 16'h0000};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 32'h0000_0001, 16'h0001, 16'hFE01};
    vecs[3] = '{16'hFFFE, 16'h0003, 1'b1, 1'b0, 32'hFFFF_FFFA, 16'h0000, 16'h02FA};
    vecs[4] = '{16'h0312, 16'h0405, 1'b0, 1'b0, 32'h000C_575A, 16'h000C, 16'h005A};
    vecs[5] = '{16'h0001, 16'h8000, 1'b0, 1'b0, 32'h0000_8000, 16'h0000, 16'h0000};

    // Reset state, with live-looking inputs that must not leak through.
    mon_en = 1'b1;
    drive(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valid", {31'b0, VALID_OUT}, 32'd0);
    chk("rst_prod", {MULT_16x16_HI, MULT_16x16_LO}, 32'd0);
    chk("rst_8x8", {MULT_8x8_TOP, MULT_8x8_BOT}, 32'd0);
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);

    // Directed table: single pulse, result exactly LAT cycles later.
    foreach (vecs[i]) begin
      logic [31:0] pe;
      @(posedge CLK); #1;
      drive(vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs, 1'b1);
      @(posedge CLK); #1;
      VALID_IN = 1'b0;
      repeat (LAT - 1) @(posedge CLK);
      @(negedge CLK);
      pe = vecs[i].p + RND;
      chk($sformatf("vec%0d_valid", i), {31'b0, VALID_OUT}, 32'd1);
      chk($sformatf("vec%0d_prod", i), {MULT_16x16_HI, MULT_16x16_LO}, pe);
      chk($sformatf("vec%0d_8x8", i), {MULT_8x8_TOP, MULT_8x8_BOT}, {vecs[i].top, vecs[i].bot});
      @(negedge CLK);
      chk($sformatf("vec%0d_after", i), {31'b0, VALID_OUT}, 32'd0);
    end

    // Back-to-back X, Y with CE low for two edges: X needs 5 clocks.
    begin
      exp_t ex, ey;
      ex = model(16'h1357, 16'h2468, 1'b0, 1'b1);
      ey = model(16'hABCD, 16'h00FF, 1'b1, 1'b0);
      @(posedge CLK); #1;
      drive(16'h1357, 16'h2468, 1'b0, 1'b1, 1'b1);
      @(posedge CLK); #1;
      drive(16'hABCD, 16'h00FF, 1'b1, 1'b0, 1'b1);
      @(posedge CLK); #1;
      VALID_IN = 1'b0;
      CE = 1'b0;
      @(negedge CLK);
      chk("stall_e2", {31'b0, VALID_OUT}, 32'd0);
      @(negedge CLK);
      chk("stall_e3", {31'b0, VALID_OUT}, 32'd0);
      @(negedge CLK);
      chk("stall_e4", {31'b0, VALID_OUT}, 32'd0);
      CE = 1'b1;
      @(negedge CLK);
      chk("stall_x_valid", {31'b0, VALID_OUT}, 32'd1);
      chk("stall_x_prod", {MULT_16x16_HI, MULT_16x16_LO}, {ex.hi, ex.lo});
      @(negedge CLK);
      chk("stall_y_valid", {31'b0, VALID_OUT}, 32'd1);
      chk("stall_y_prod", {MULT_16x16_HI, MULT_16x16_LO}, {ey.hi, ey.lo});
      chk("stall_y_8x8", {MULT_8x8_TOP, MULT_8x8_BOT}, {ey.top, ey.bot});
      @(negedge CLK);
      chk("stall_end", {31'b0, VALID_OUT}, 32'd0);
    end

    // Reset with two samples in flight: immediate clear, nothing stale later.
    @(posedge CLK); #1;
    drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    @(posedge CLK); #1;
    drive(16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 1'b1);
    @(posedge CLK); #1;
    VALID_IN = 1'b0;
    RST = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, VALID_OUT}, 32'd0);
    chk("midrst_prod", {MULT_16x16_HI, MULT_16x16_LO}, 32'd0);
    chk("midrst_8x8", {MULT_8x8_TOP, MULT_8x8_BOT}, 32'd0);
    #2;
    RST = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge CLK);
      chk("postrst_valid", {31'b0, VALID_OUT}, 32'd0);
      chk("postrst_prod", {MULT_16x16_HI, MULT_16x16_LO}, 32'd0);
    end

    // Random traffic with random bubbles and stalls; monitor checks every cycle.
    for (int c = 0; c < 400; c++) begin
      @(posedge CLK); #1;
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 99) < 60));
      CE = ($urandom_range(0, 99) < 80);
    end
    @(posedge CLK); #1;
    VALID_IN = 1'b0;
    CE = 1'b1;
    repeat (LAT + 2) @(posedge CLK);
    @(negedge CLK);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
